// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and byte-selection helpers for the score LCD driver.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_ROW0     = 8'h80;

    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_1     = 8'h31;
    localparam logic [7:0] ASC_2     = 8'h32;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_SNAP,
        ST_REFRESH,
        ST_IDLE
    } lcd_state_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        WR_WAIT
    } wr_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cyc_width(input int m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [7:0] init_cmd(input logic [3:0] idx);
        case (idx)
            4'd0:    return LCD_FUNC_SET;
            4'd1:    return LCD_DISP_ON;
            4'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

    // Row 0 layout: "P1:a  P2:b" preceded by the DDRAM address command.
    function automatic logic [7:0] refresh_byte(input logic [3:0] idx,
                                                input logic [7:0] s1,
                                                input logic [7:0] s2);
        case (idx)
            4'd0:       return LCD_ROW0;
            4'd1:       return ASC_P;
            4'd2:       return ASC_1;
            4'd3:       return ASC_COLON;
            4'd4:       return s1;
            4'd5, 4'd6: return ASC_SPACE;
            4'd7:       return ASC_P;
            4'd8:       return ASC_2;
            4'd9:       return ASC_COLON;
            default:    return s2;
        endcase
    endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One HD44780 byte write: SETUP, EN pulse, HOLD, then the command execution wait.
module lcd_write_cycle
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int CLEAR_CYC = 82000,
    parameter int CW        = 17
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data_in,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       done
);

    wr_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   wait_last;

    // Only the clear command (RS=0) needs the long execution time.
    assign wait_last = (!lcd_rs && lcd_data == LCD_CLEAR) ? CW'(CLEAR_CYC - 1)
                                                         : CW'(EXEC_CYC - 1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= WR_IDLE;
            cnt      <= '0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            lcd_en <= (state_n == WR_PULSE);
            if (state == WR_IDLE && start) begin
                lcd_rs   <= rs;
                lcd_data <= data_in;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        done    = 1'b0;
        case (state)
            WR_IDLE: begin
                cnt_n = '0;
                if (start) state_n = WR_SETUP;
            end
            WR_SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
                state_n = WR_PULSE;
                cnt_n   = '0;
            end
            WR_PULSE: if (cnt == CW'(EN_CYC - 1)) begin
                state_n = WR_HOLD;
                cnt_n   = '0;
            end
            WR_HOLD: if (cnt == CW'(HOLD_CYC - 1)) begin
                state_n = WR_WAIT;
                cnt_n   = '0;
            end
            WR_WAIT: if (cnt == wait_last) begin
                state_n = WR_IDLE;
                cnt_n   = '0;
                done    = 1'b1;
            end
            default: begin
                state_n = WR_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/score_lcd_driver.sv
// Shows both pong scores as "P1:a  P2:b" on a 16x2 HD44780 LCD, rewriting only on change.
module score_lcd_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int EN_CYC      = 12,
    parameter int HOLD_CYC    = 2,
    parameter int EXEC_CYC    = 2000,
    parameter int CLEAR_CYC   = 82000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] in_p1_char,
    input  logic [7:0] in_p2_char,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       out_ready
);

    localparam int MAXC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(EN_CYC, HOLD_CYC)),
                               max2(EXEC_CYC, CLEAR_CYC));
    localparam int CW   = cyc_width(MAXC);

    lcd_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic          pending, pending_n;
    logic [7:0]    s1, s2;
    logic          start, snap, sel_rs, done;
    logic [7:0]    sel_byte;

    assign LCD_RW = 1'b0;

    lcd_write_cycle #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .EXEC_CYC  (EXEC_CYC),
        .CLEAR_CYC (CLEAR_CYC),
        .CW        (CW)
    ) u_write (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .rs       (sel_rs),
        .data_in  (sel_byte),
        .lcd_data (LCD_DATA),
        .lcd_rs   (LCD_RS),
        .lcd_en   (LCD_EN),
        .done     (done)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_POWERUP;
            cnt       <= '0;
            idx       <= '0;
            pending   <= 1'b0;
            s1        <= '0;
            s2        <= '0;
            out_ready <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            pending   <= pending_n;
            out_ready <= (state_n == ST_IDLE);
            if (snap) begin
                s1 <= in_p1_char;
                s2 <= in_p2_char;
            end
        end
    end

    // A write is launched once per index; pending blocks relaunch until its done.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        start    = 1'b0;
        snap     = 1'b0;
        sel_rs   = 1'b0;
        sel_byte = 8'h00;
        case (state)
            ST_POWERUP: begin
                if (cnt == CW'(POWERUP_CYC - 1)) begin
                    state_n = ST_INIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_INIT: begin
                sel_byte = init_cmd(idx);
                start    = !pending;
                if (done) begin
                    if (idx == 4'd3) begin
                        state_n = ST_SNAP;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            ST_SNAP: begin
                snap    = 1'b1;
                state_n = ST_REFRESH;
            end
            ST_REFRESH: begin
                sel_rs   = (idx != 4'd0);
                sel_byte = refresh_byte(idx, s1, s2);
                start    = !pending;
                if (done) begin
                    if (idx == 4'd10) begin
                        state_n = ST_IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (in_p1_char != s1 || in_p2_char != s2) state_n = ST_SNAP;
            end
            default: state_n = ST_POWERUP;
        endcase
        pending_n = done ? 1'b0 : (start ? 1'b1 : pending);
    end

endmodule

// File: doc/score_lcd_driver.md
Name: score_lcd_driver

Overview:
- Downstream consumer of the pong top-level score outputs; its ASCII score inputs are wired from the game's out_Player1/out_Player2.
- Drives an HD44780-compatible 16x2 character LCD in 8-bit write-only mode.
- After power-up initialisation, writes "P1:a  P2:b" on row 0, where a and b are the score characters.
- Rewrites the row only when either score differs from the last displayed value.

Parameters:
POWERUP_CYC, 750000, CLK cycles of wait after reset release before the first command (15 ms at 50 MHz)
SETUP_CYC, 2, cycles RS/DATA are stable with EN low before the EN pulse
EN_CYC, 12, cycles EN is held high (at least 230 ns)
HOLD_CYC, 2, cycles RS/DATA are held after EN falls
EXEC_CYC, 2000, execution wait after a normal command or data write (40 us)
CLEAR_CYC, 82000, execution wait after the clear command 0x01 (1.64 ms)

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  asynchronous, active-high reset
in_p1_char  in  8  player-1 score, ASCII
in_p2_char  in  8  player-2 score, ASCII
LCD_DATA  out  8  LCD data bus
LCD_RS  out  1  register select: 0 = command, 1 = data
LCD_RW  out  1  read/write; tied to 0 (write only)
LCD_EN  out  1  LCD enable strobe
out_ready  out  1  high while the block is idle with the display up to date

Behaviour:
- Reset values: LCD_DATA=0x00, LCD_RS=0, LCD_EN=0, LCD_RW=0, out_ready=0, all counters 0, FSM in POWERUP.
- Reset mid-operation forces LCD_EN low immediately (asynchronous); the full init sequence reruns after release.
- Byte write cycle, sub-module, started by a 1-cycle start pulse with the rs and byte inputs:
  - SETUP: EN=0, RS and DATA driven, for SETUP_CYC cycles.
  - PULSE: EN=1 for EN_CYC cycles.
  - HOLD: EN=0, RS and DATA unchanged, for HOLD_CYC cycles.
  - WAIT: for CLEAR_CYC cycles if the byte is command 0x01, otherwise EXEC_CYC cycles.
  - done pulses for 1 cycle on the last WAIT cycle.
  - Total length is SETUP_CYC+EN_CYC+HOLD_CYC+wait cycles.
  - Exactly one EN pulse per byte.
- Main FSM states: POWERUP -> INIT -> SNAP -> REFRESH -> IDLE.
- POWERUP: counts POWERUP_CYC cycles, then enters INIT.
- INIT: sends commands in order 0x38 (function set, 8-bit, 2 lines), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry mode, increment). Index 0..3; advances on done.
- SNAP (1 cycle): latches in_p1_char and in_p2_char into snapshot registers s1/s2, then enters REFRESH.
- REFRESH: sends 11 bytes, index 0..10:
  - index 0: command 0x80 (RS=0).
  - index 1..10: data 'P','1',':',s1,' ',' ','P','2',':',s2, all with RS=1.
  - After index 10 done, enters IDLE.
- First entry after INIT always performs a refresh, even if the scores are 0x30.
- IDLE: out_ready=1. If in_p1_char!=s1 or in_p2_char!=s2, then on the next cycle out_ready=0 and the FSM enters SNAP.
- Inputs changing during REFRESH are ignored; the comparison in IDLE catches them afterwards (one extra refresh, no byte lost or torn).
- Both scores changing in the same cycle cause a single refresh.
- Non-digit characters are passed through unmodified.
- Counter width is $clog2 of the maximum of the cycle parameters; no wrap-around occurs within a wait.
- LCD outputs are registered; no combinational path from inputs to LCD pins.

Decomposition:
- Package lcd_pkg holds:
  - command constants: LCD_FUNC_SET=0x38, LCD_DISP_ON=0x0C, LCD_CLEAR=0x01, LCD_ENTRY=0x06, LCD_ROW0=0x80;
  - ASCII constants;
  - the main-FSM state enum.
- Sub-module lcd_write_cycle: the SETUP/PULSE/HOLD/WAIT timer with start/done handshake and the timing parameters.
- The parent holds the sequencing FSM, the byte-select mux and the snapshot registers.

Test Plan:
All scenarios use reduced parameters: POWERUP_CYC=100, SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, EXEC_CYC=10, CLEAR_CYC=50.
1. Reset release with inputs 0x30/0x30 -> no EN pulse for 100 cycles; then 4 command bytes 0x38,0x0C,0x01,0x06 with RS=0; then 0x80; then data "P1:0  P2:0"; out_ready=1. EN pulse count = 15, each EN high exactly 4 cycles.
2. Timing check -> DATA/RS stable from 2 cycles before the EN rise to 2 cycles after the EN fall; the gap after 0x01 is at least 50 cycles, other gaps at least 10.
3. In IDLE, in_p1_char goes 0x30->0x31 -> out_ready falls the next cycle; 11 bytes are written with byte 4 = 0x31; out_ready returns high.
4. in_p2_char changes 0x30->0x32 mid-refresh at byte 5 -> the current refresh writes 0x30 at byte 10; a second refresh follows immediately with 0x32; exactly 22 EN pulses total.
5. RESET asserted while EN is high during INIT -> EN low in the same cycle, all outputs at reset values; after release the full POWERUP+INIT sequence repeats.
6. Both inputs change in the same cycle (0x34->0x30 on each) -> exactly one refresh containing both new values.
